psum_popcount_accum: RTL and testbench

Parametrised successor to the fixed 256-lane partial-sum adder in the binarised conv datapath. It reduces `LANES` unsigned partial sums through a registered adder tree. It then accumulates tree results over a configurable number of input beats, so channel groups wider than one beat are supported. Each completed group yields a thresholded bit and a saturated raw sum. The block sits between the PE array and the ofmap BRAM writer and adds full valid/ready backpressure.

---
 rtl/psum_popcount_accum_if.sv | 31 +++
 rtl/psum_popcount_accum.sv | 169 ++++++++++++++++
 tb/tb_psum_popcount_accum.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_popcount_accum_if.sv
// Beat-in / group-out handshake bundle for psum_popcount_accum.
// slave: DUT side (psum_in/addr_in/i_last/i_valid/o_ready in; i_ready and o_* out).
interface psum_popcount_accum_if #(
   parameter int LANES  = 256,
   parameter int LANE_W = 5,
   parameter int ADDR_W = 12,
   parameter int ACC_W  = 16
);
   logic [LANES*LANE_W-1:0] psum_in;
   logic [ADDR_W-1:0]       addr_in;
   logic                    i_last;
   logic                    i_valid;
   logic                    i_ready;
   logic                    o_valid;
   logic                    o_ready;
   logic                    o_bit;
   logic [ACC_W-1:0]        o_sum;
   logic                    o_sat;
   logic [ADDR_W-1:0]       o_addr;
   logic                    o_last;

   modport master (
      output psum_in, addr_in, i_last, i_valid, o_ready,
      input  i_ready, o_valid, o_bit, o_sum, o_sat, o_addr, o_last
   );

   modport slave (
      input  psum_in, addr_in, i_last, i_valid, o_ready,
      output i_ready, o_valid, o_bit, o_sum, o_sat, o_addr, o_last
   );
endinterface

// File: rtl/psum_popcount_accum.sv
// Registered partial-sum adder tree with multi-beat group accumulate and threshold.
// Ports: clk, rst_n, clear, pass_count, threshold, bin_mode; bus = beat in / result out.
module psum_popcount_accum #(
   parameter int LANES  = 256,
   parameter int LANE_W = 5,
   parameter int ADDR_W = 12,
   parameter int ACC_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic [7:0]          pass_count,
   input  logic [ACC_W-1:0]    threshold,
   input  logic                bin_mode,
   psum_popcount_accum_if.slave bus
);
   localparam int L  = $clog2(LANES);
   localparam int TW = LANE_W + L;

   logic en;
   logic o_valid_q;

   assign en          = ~(o_valid_q & ~bus.o_ready);
   assign bus.i_ready = en;
   assign bus.o_valid = o_valid_q;

   // Level 0 is the input register; level k holds LANES>>k sums of LANE_W+k bits.
   for (genvar k = 0; k <= L; k++) begin : g_lvl
      localparam int W = LANE_W + k;
      localparam int N = LANES >> k;
      logic [N*W-1:0]    dat;
      logic [ADDR_W-1:0] addr;
      logic              last;
      logic              v;
      logic [N*W-1:0]    nxt;
      logic [ADDR_W-1:0] naddr;
      logic              nlast;
      logic              nv;

      if (k == 0) begin : g_in
         assign nxt   = bus.psum_in;
         assign naddr = bus.addr_in;
         assign nlast = bus.i_last;
         assign nv    = bus.i_valid;
      end else begin : g_add
         always_comb begin
            nxt = '0;
            for (int j = 0; j < N; j++) begin
               nxt[j*W +: W] = W'(g_lvl[k-1].dat[2*j*(W-1) +: W-1])
                             + W'(g_lvl[k-1].dat[(2*j+1)*(W-1) +: W-1]);
            end
         end
         assign naddr = g_lvl[k-1].addr;
         assign nlast = g_lvl[k-1].last;
         assign nv    = g_lvl[k-1].v;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v    <= 1'b0;
            dat  <= '0;
            addr <= '0;
            last <= 1'b0;
         end else if (clear) begin
            v <= 1'b0;
         end else if (en) begin
            v <= nv;
            if (nv) begin
               dat  <= nxt;
               addr <= naddr;
               last <= nlast;
            end
         end
      end
   end

   // Tree root is re-registered so the saturating add/compare has a full cycle.
   logic [TW-1:0]     ts_sum;
   logic [ADDR_W-1:0] ts_addr;
   logic              ts_last;
   logic              ts_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_v    <= 1'b0;
         ts_sum  <= '0;
         ts_addr <= '0;
         ts_last <= 1'b0;
      end else if (clear) begin
         ts_v <= 1'b0;
      end else if (en) begin
         ts_v <= g_lvl[L].v;
         if (g_lvl[L].v) begin
            ts_sum  <= g_lvl[L].dat;
            ts_addr <= g_lvl[L].addr;
            ts_last <= g_lvl[L].last;
         end
      end
   end

   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             sat_grp;
   logic [ACC_W:0]   s_full;
   logic [ACC_W-1:0] s;
   logic             sat_now;
   logic [8:0]       pc;
   logic             done;

   always_comb begin
      s_full  = {1'b0, acc} + (ACC_W+1)'(ts_sum);
      sat_now = s_full[ACC_W];
      s       = sat_now ? '1 : s_full[ACC_W-1:0];
      pc      = (pass_count == 8'd0) ? 9'd1 : {1'b0, pass_count};
      done    = (({1'b0, cnt} + 9'd1) == pc) | ts_last;
   end

   logic             o_bit_q;
   logic [ACC_W-1:0] o_sum_q;
   logic             o_sat_q;
   logic [ADDR_W-1:0] o_addr_q;
   logic             o_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         sat_grp   <= 1'b0;
         o_valid_q <= 1'b0;
         o_bit_q   <= 1'b0;
         o_sum_q   <= '0;
         o_sat_q   <= 1'b0;
         o_addr_q  <= '0;
         o_last_q  <= 1'b0;
      end else if (clear) begin
         acc       <= '0;
         cnt       <= '0;
         sat_grp   <= 1'b0;
         o_valid_q <= 1'b0;
      end else if (en) begin
         if (ts_v && done) begin
            o_valid_q <= 1'b1;
            o_sum_q   <= s;
            o_bit_q   <= bin_mode & (s >= threshold);
            o_sat_q   <= sat_grp | sat_now;
            o_addr_q  <= ts_addr;
            o_last_q  <= ts_last;
            acc       <= '0;
            cnt       <= '0;
            sat_grp   <= 1'b0;
         end else begin
            if (o_valid_q && bus.o_ready) begin
               o_valid_q <= 1'b0;
            end
            if (ts_v) begin
               acc     <= s;
               cnt     <= cnt + 8'd1;
               sat_grp <= sat_grp | sat_now;
            end
         end
      end
   end

   assign bus.o_bit  = o_bit_q;
   assign bus.o_sum  = o_sum_q;
   assign bus.o_sat  = o_sat_q;
   assign bus.o_addr = o_addr_q;
   assign bus.o_last = o_last_q;
endmodule

// File: tb/tb_psum_popcount_accum.sv
// Scoreboard bench for psum_popcount_accum at default parameters.
// Expected group results are queued as beats are accepted and checked on output.
module tb_psum_popcount_accum;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic [7:0]  pass_count = 8'd1;
   logic [15:0] threshold = 16'd640;
   logic        bin_mode = 1'b1;

   psum_popcount_accum_if bus ();

   psum_popcount_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .pass_count (pass_count),
      .threshold  (threshold),
      .bin_mode   (bin_mode),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sum;
      bit b;
      bit sat;
      int addr;
      bit last;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_sum(input int total);
      int rem;
      rem = total;
      for (int i = 0; i < 256; i++) begin
         int v;
         v = (rem > 31) ? 31 : rem;
         bus.psum_in[i*5 +: 5] = 5'(v);
         rem -= v;
      end
   endtask

   task automatic set_uni(input int v);
      for (int i = 0; i < 256; i++) bus.psum_in[i*5 +: 5] = 5'(v);
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input int a, input bit lst);
      int  n;
      bit  took;
      bus.addr_in = 12'(a);
      bus.i_last  = lst;
      bus.i_valid = 1'b1;
      n = 0;
      forever begin
         took = bus.i_ready;
         @(posedge clk);
         #1;
         if (took) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(bus.i_ready), 1);
            break;
         end
         @(negedge clk);
      end
      acc_cyc = cyc;
      @(negedge clk);
      bus.i_valid = 1'b0;
   endtask

   task automatic beat(input int total, input int a, input bit lst);
      set_sum(total);
      send(a, lst);
   endtask

   task automatic expect_out(input int s, input bit b, input bit sat,
                             input int a, input bit lst, input int c);
      exp_t e;
      e.sum = s; e.b = b; e.sat = sat;
      e.addr = a; e.last = lst; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(q.size()), 0);
      repeat (14) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.o_valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 32'(bus.o_valid), 0);
         end else begin
            e = q[0];
            chk("o_sum", 32'(bus.o_sum), 32'(e.sum));
            chk("o_bit", 32'(bus.o_bit), 32'(e.b));
            chk("o_sat", 32'(bus.o_sat), 32'(e.sat));
            chk("o_addr", 32'(bus.o_addr), 32'(e.addr));
            chk("o_last", 32'(bus.o_last), 32'(e.last));
            if (!bus.o_ready) begin
               chk("i_ready_stall", 32'(bus.i_ready), 0);
            end else begin
               if (e.cyc >= 0) chk("latency", 32'(cyc), 32'(e.cyc));
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      bus.psum_in = '0;
      bus.addr_in = '0;
      bus.i_last  = 1'b0;
      bus.i_valid = 1'b0;
      bus.o_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_o_valid", 32'(bus.o_valid), 0);
      chk("rst_o_bit", 32'(bus.o_bit), 0);
      chk("rst_o_sum", 32'(bus.o_sum), 0);
      chk("rst_o_sat", 32'(bus.o_sat), 0);
      chk("rst_o_addr", 32'(bus.o_addr), 0);
      chk("rst_o_last", 32'(bus.o_last), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_i_ready", 32'(bus.i_ready), 1);

      // exact latency, all lanes 5
      set_uni(5);
      send('h123, 1'b0);
      expect_out(1280, 1, 0, 'h123, 0, acc_cyc + 10);
      drain();

      // threshold boundary
      beat(640, 1, 1'b0);
      expect_out(640, 1, 0, 1, 0, -1);
      beat(639, 2, 1'b0);
      expect_out(639, 0, 0, 2, 0, -1);
      drain();
      bin_mode = 1'b0;
      beat(640, 3, 1'b0);
      expect_out(640, 0, 0, 3, 0, -1);
      beat(639, 4, 1'b0);
      expect_out(639, 0, 0, 4, 0, -1);
      drain();
      bin_mode = 1'b1;

      // multi-beat group
      pass_count = 8'd3;
      beat(100, 7, 1'b0);
      beat(200, 8, 1'b0);
      beat(300, 9, 1'b0);
      expect_out(600, 0, 0, 9, 0, -1);
      drain();

      // short group closed by i_last, then a fresh full group
      beat(50, 10, 1'b0);
      beat(60, 11, 1'b1);
      expect_out(110, 0, 0, 11, 1, -1);
      beat(1, 12, 1'b0);
      beat(1, 13, 1'b0);
      beat(1, 14, 1'b0);
      expect_out(3, 0, 0, 14, 0, -1);
      drain();

      // backpressure: o_ready low 5 cycles mid-stream
      pass_count = 8'd1;
      fork
         begin
            repeat (11) @(posedge clk);
            #2 bus.o_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2 bus.o_ready = 1'b1;
         end
      join_none
      for (int i = 0; i < 6; i++) begin
         beat(600 + 100 * i, 20 + i, 1'b0);
         expect_out(600 + 100 * i, (i > 0), 0, 20 + i, 0, -1);
         repeat (2) @(negedge clk);
      end
      drain();

      // saturation
      pass_count = 8'd9;
      for (int i = 0; i < 9; i++) beat(7936, 30 + i, 1'b0);
      expect_out(65535, 1, 1, 38, 0, -1);
      drain();

      // flush a partial group with beats still in the tree
      for (int i = 0; i < 4; i++) beat(7936, 40 + i, 1'b0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("i_ready_after_clear", 32'(bus.i_ready), 1);
      repeat (15) @(negedge clk);
      for (int i = 0; i < 9; i++) beat(10, 50 + i, 1'b0);
      expect_out(90, 0, 0, 58, 0, -1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
